output4to1_sync: RTL and testbench

- Output-side counterpart of the router's 1-to-4 input demux.
- Merges four two-phase bundled-data channels into one two-phase output channel toward the neighbour or local port. The four inputs come from the demuxes of the other input ports.
- Clocked merge: each input req is synchronised, a round-robin arbiter grants one pending input per cycle, and the granted flit goes into a small FIFO.
- A transmit FSM drains the FIFO onto the output channel and waits for the synchronised out_ack.

---
 rtl/router_pkg.sv | 14 +
 rtl/rr_arbiter4.sv | 30 +++
 rtl/output4to1_sync.sv | 144 ++++++++++++++
 tb/tb_output4to1_sync.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types for the router's port muxing logic.
package router_pkg;

    localparam int NUM_IN_PORTS = 4;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_WAIT
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter; the pointer register lives in the parent.
module rr_arbiter4
    import router_pkg::*;
(
    input  logic [NUM_IN_PORTS-1:0] pending,
    input  logic                    enable,
    input  port_idx_t               ptr,
    output logic                    grant_valid,
    output port_idx_t               grant_idx
);

    port_idx_t cand;

    // Search ptr+1 .. ptr+4 cyclically so the last winner has lowest priority.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        if (enable) begin
            for (int k = 1; k <= NUM_IN_PORTS; k++) begin
                cand = ptr + port_idx_t'(k);
                if (!grant_valid && pending[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/output4to1_sync.sv
// Merges four two-phase bundled-data channels into one output channel via
// synchronisers, a round-robin arbiter, a small FIFO and a transmit FSM.
module output4to1_sync
    import router_pkg::*;
#(
    parameter int n           = 32,
    parameter int DEPTH       = 2,  // power of 2, >= 2
    parameter int SYNC_STAGES = 2   // >= 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN_PORTS-1:0]   in_req,
    output logic [NUM_IN_PORTS-1:0]   in_ack,
    input  logic [NUM_IN_PORTS*n-1:0] in_data,
    output logic                      out_req,
    input  logic                      out_ack,
    output logic [n-1:0]              out_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [SYNC_STAGES-1:0][NUM_IN_PORTS-1:0] req_sync;
    logic [SYNC_STAGES-1:0]                   ack_sync;
    logic [NUM_IN_PORTS-1:0]                  req_s;
    logic                                     ack_s;
    logic [NUM_IN_PORTS-1:0]                  pending;

    logic [n-1:0]  in_word [NUM_IN_PORTS];
    logic [n-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_d;
    logic          has_room;
    logic          push;
    logic          pop;

    port_idx_t     rr_ptr;
    port_idx_t     grant_idx;
    logic          grant_valid;
    tx_state_t     state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync <= '0;
            ack_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], in_req};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
        end
    end

    assign req_s   = req_sync[SYNC_STAGES-1];
    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign pending = req_s ^ in_ack;

    always_comb begin
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            in_word[i] = in_data[i*n +: n];
        end
    end

    // Room is judged on the registered count, so a pop never frees a slot
    // for a grant in the same cycle.
    assign has_room = (count < FULL_CNT);

    rr_arbiter4 u_arb (
        .pending     (pending),
        .enable      (has_room),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign push = grant_valid;
    assign pop  = (state == TX_IDLE) && (count != '0);

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_word[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= 2'd3;
            in_ack <= '0;
        end else begin
            count <= count_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= grant_idx;
                in_ack <= in_ack ^ (4'b0001 << grant_idx);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // SETUP gives out_data a full cycle ahead of the req transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            out_req  <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop) begin
                        out_data <= mem[rd_ptr];
                        state    <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    out_req <= ~out_req;
                    state   <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (ack_s == out_req) begin
                        state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    count_le_depth: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);

endmodule

// File: tb/tb_output4to1_sync.sv
// Self-checking bench for output4to1_sync: latency table, round-robin order,
// backpressure, full/pop boundary, two-phase continuity and async reset.
module tb_output4to1_sync;

    localparam int N  = 32;
    localparam int SS = 2;

    logic          clk;
    logic          rst;
    logic [3:0]    in_req;
    logic [3:0]    in_ack;
    logic [4*N-1:0] in_data;
    logic          out_req;
    logic          out_ack;
    logic [N-1:0]  out_data;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic          resp_hold = 1'b0;
    logic [31:0]   sb[$];

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic        exp_req;
    } vec_t;

    vec_t vecs[4];

    output4to1_sync #(
        .n           (N),
        .DEPTH       (2),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Downstream model: acks each out_req transition and checks data order.
    initial begin
        out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_ack = 1'b0;
            end else if (out_req != out_ack && !resp_hold) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out_req: got data %h, expected no transfer", out_data);
                end else begin
                    check("out_data_order", out_data, sb.pop_front());
                end
                out_ack = out_req;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_req    = '0;
        resp_hold = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        check("reset_in_ack", 32'(in_ack), 32'h0);
        check("reset_out_req", 32'(out_req), 32'h0);
        check("reset_out_data", out_data, 32'h0);
        rst = 1'b0;
    endtask

    task automatic send(input int p, input logic [31:0] d);
        int t;
        t = 0;
        while (in_ack[p] != in_req[p] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_timeout", 32'(t < 50), 32'h1);
        in_data[p*N +: N] = d;
        in_req[p]         = ~in_req[p];
        sb.push_back(d);
    endtask

    task automatic wait_drain(input int max_cyc);
        int t;
        t = 0;
        while ((sb.size() != 0 || out_req != out_ack || in_req != in_ack) && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(t < max_cyc), 32'h1);
    endtask

    task automatic wait_out_req(input logic lvl);
        int t;
        t = 0;
        while (out_req != lvl && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("out_req_timeout", 32'(out_req), 32'(lvl));
    endtask

    initial begin
        int t;
        int t_pop;
        int changes;
        logic lvl;

        vecs[0] = '{2, 32'hA5A5_0001, 4'b0100, 1'b1};
        vecs[1] = '{0, 32'hDEAD_BEEF, 4'b0001, 1'b1};
        vecs[2] = '{3, 32'hFFFF_FFFF, 4'b1000, 1'b1};
        vecs[3] = '{1, 32'h1234_5678, 4'b0010, 1'b1};

        rst     = 1'b1;
        in_req  = '0;
        in_data = '0;
        do_reset();

        // Single-flit latency from a fresh reset.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            @(negedge clk);
            in_data[vecs[i].port*N +: N] = vecs[i].data;
            in_req[vecs[i].port]         = 1'b1;
            sb.push_back(vecs[i].data);
            @(negedge clk);
            @(negedge clk);
            check("lat_ack_early", 32'(in_ack), 32'h0);
            @(negedge clk);
            check("lat_ack_edge2", 32'(in_ack), 32'(vecs[i].exp_ack));
            @(negedge clk);
            check("lat_data_edge3", out_data, vecs[i].data);
            check("lat_req_edge3", 32'(out_req), 32'h0);
            @(negedge clk);
            check("lat_req_edge4", 32'(out_req), 32'(vecs[i].exp_req));
            wait_drain(40);
            repeat (8) @(negedge clk);
            check("no_extra_req", 32'(out_req), 32'(vecs[i].exp_req));
        end

        // Round-robin: all four at once, then 0 and 3 together.
        do_reset();
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            in_data[p*N +: N] = 32'hC0DE_0000 + 32'(p);
            sb.push_back(32'hC0DE_0000 + 32'(p));
        end
        in_req = 4'hF;
        wait_drain(200);
        @(negedge clk);
        in_data[0*N +: N] = 32'hBEEF_0000;
        in_data[3*N +: N] = 32'hBEEF_0003;
        sb.push_back(32'hBEEF_0000);
        sb.push_back(32'hBEEF_0003);
        in_req = in_req ^ 4'b1001;
        wait_drain(200);
        check("rr_final_ack", 32'(in_ack), 32'(4'b0110));

        // Two-phase continuity on port 1.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            send(1, 32'h7700_0000 + 32'(k));
            wait_drain(100);
            lvl = (k % 2 == 0);
            check("cont_in_ack1", 32'(in_ack[1]), 32'(lvl));
            check("cont_out_req", 32'(out_req), 32'(lvl));
        end

        // Backpressure with output stalled, then the full/pop boundary.
        do_reset();
        resp_hold = 1'b1;
        @(negedge clk);
        send(3, 32'h3333_0003);
        wait_out_req(1'b1);
        @(negedge clk);
        send(0, 32'h3333_0000);
        send(1, 32'h3333_0001);
        send(2, 32'h3333_0002);
        repeat (12) @(negedge clk);
        check("bp_in_ack_held", 32'(in_ack), 32'(4'b1011));
        resp_hold = 1'b0;
        t     = 0;
        t_pop = -1;
        while (t < 15 && t_pop < 0) begin
            @(negedge clk);
            t++;
            if (out_data == 32'h3333_0000) t_pop = t;
        end
        check("bp_pop_seen", 32'(t_pop > 0), 32'h1);
        check("full_no_grant_on_pop", 32'(in_ack[2]), 32'h0);
        @(negedge clk);
        t++;
        check("full_grant_next_edge", 32'(in_ack[2]), 32'h1);
        check("bp_grant_latency", 32'(t <= SS + 4), 32'h1);
        wait_drain(200);

        // Asynchronous reset while waiting on out_ack with one entry queued.
        do_reset();
        resp_hold = 1'b1;
        @(negedge clk);
        send(0, 32'h5555_0000);
        wait_out_req(1'b1);
        @(negedge clk);
        send(1, 32'h5555_0001);
        t = 0;
        while (in_ack[1] != 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("rst_setup_fifo_entry", 32'(in_ack[1]), 32'h1);
        #2;
        rst    = 1'b1;
        in_req = '0;
        #1;
        check("async_rst_out_req", 32'(out_req), 32'h0);
        check("async_rst_in_ack", 32'(in_ack), 32'h0);
        check("async_rst_out_data", out_data, 32'h0);
        sb.delete();
        resp_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        changes = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_req != 1'b0) changes++;
        end
        check("post_rst_no_req", 32'(changes), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
